// File: rtl/tile_query_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tile_query_arbiter
// Description : Round-robin shared tilemap/dot lookup port for the player and
//               ghost movers. One grant per cycle; a two-stage pipeline turns
//               the granted pixel coordinate into a tile index and returns
//               wall/dot/out-of-bounds flags tagged with the requester id.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_query_arbiter #(
  parameter int NREQ   = 5,
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int TILE   = 20,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT),
  parameter int NT     = (WIDTH / TILE) * (HEIGHT / TILE),
  parameter int IW     = $clog2(NT),
  parameter int DW     = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ*XW-1:0] i_qx,
  input  logic [NREQ*YW-1:0] i_qy,
  input  logic [NT-1:0]      i_tilemap,
  input  logic [NT-1:0]      i_dots,
  output logic [NREQ-1:0]    o_gnt,
  output logic               o_rsp_valid,
  output logic [DW-1:0]      o_rsp_id,
  output logic [IW-1:0]      o_rsp_idx,
  output logic               o_rsp_wall,
  output logic               o_rsp_dot,
  output logic               o_rsp_oob
);

  localparam int c_cols = WIDTH / TILE;

  // Arbitration state and stage-B capture registers
  logic [DW-1:0]   r_ptr;
  logic [NREQ-1:0] r_gnt;
  logic            r_b_valid;
  logic [DW-1:0]   r_b_id;
  logic [XW-1:0]   r_bx;
  logic [YW-1:0]   r_by;

  // Response registers
  logic            r_rsp_valid;
  logic [DW-1:0]   r_rsp_id;
  logic [IW-1:0]   r_rsp_idx;
  logic            r_rsp_wall;
  logic            r_rsp_dot;
  logic            r_rsp_oob;

  // Combinational arbitration / index logic
  logic            w_found;
  logic [DW-1:0]   w_win;
  logic [DW-1:0]   w_ptr_nxt;
  logic            w_oob;
  logic [XW-1:0]   w_col;
  logic [YW-1:0]   w_row;
  logic [IW-1:0]   w_idx;
  logic [IW-1:0]   w_sidx;

  // Scan requests starting at the pointer, wrapping; first set bit wins
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int o = 0; o < NREQ; o++) begin
      if (!w_found && i_req[(int'(r_ptr) + o) % NREQ]) begin
        w_found = 1'b1;
        w_win   = DW'((int'(r_ptr) + o) % NREQ);
      end
    end
  end

  assign w_ptr_nxt = (w_win == DW'(NREQ - 1)) ? '0 : w_win + 1'b1;

  // Grant pulse, pointer advance and capture of the winner's coordinate
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_b_valid <= 1'b0;
      r_b_id    <= '0;
      r_bx      <= '0;
      r_by      <= '0;
    end else begin
      r_b_valid <= w_found;
      if (w_found) begin
        r_gnt  <= NREQ'(1) << w_win;
        r_ptr  <= w_ptr_nxt;
        r_b_id <= w_win;
        r_bx   <= i_qx[int'(w_win)*XW +: XW];
        r_by   <= i_qy[int'(w_win)*YW +: YW];
      end else begin
        r_gnt  <= '0;
      end
    end
  end

  // Coordinate to tile index; constant divisions truncate toward zero.
  // Out-of-bounds coordinates are steered to index 0 so the lookup never
  // addresses past the end of the tile vectors.
  assign w_oob  = (int'(r_bx) >= WIDTH) || (int'(r_by) >= HEIGHT);
  assign w_col  = r_bx / XW'(TILE);
  assign w_row  = r_by / YW'(TILE);
  assign w_idx  = IW'(w_row) * IW'(c_cols) + IW'(w_col);
  assign w_sidx = w_oob ? '0 : w_idx;

  // Lookup stage: tilemap/dots sampled live; data holds when no response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_idx   <= '0;
      r_rsp_wall  <= 1'b0;
      r_rsp_dot   <= 1'b0;
      r_rsp_oob   <= 1'b0;
    end else begin
      r_rsp_valid <= r_b_valid;
      if (r_b_valid) begin
        r_rsp_id   <= r_b_id;
        r_rsp_idx  <= w_sidx;
        r_rsp_wall <= w_oob | ~i_tilemap[w_sidx];
        r_rsp_dot  <= ~w_oob & i_dots[w_sidx];
        r_rsp_oob  <= w_oob;
      end
    end
  end

  assign o_gnt       = r_gnt;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_idx   = r_rsp_idx;
  assign o_rsp_wall  = r_rsp_wall;
  assign o_rsp_dot   = r_rsp_dot;
  assign o_rsp_oob   = r_rsp_oob;

endmodule
`default_nettype wire
